// File: rtl/uart_rx_frame_counter_pkg.sv
// Shared constants and state encoding for the UART receive frame counter.
package uart_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int MIN_PRESCALE   = 4;
  localparam int MIN_FRAME_BITS = 2;
  localparam int RST_PRESCALE   = 8;
  localparam int RST_FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_frame_counter_if.sv
// Signal bundle around the frame counter: control inputs and timing strobes.
interface uart_rx_frame_counter_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  // enable is a per-cycle qualifier, not a handshake: every cycle it is high
  // (and clear is low) the counters advance by one oversampling edge.
  logic                  enable;
  logic                  clear;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  frame_bits;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  sample_en;
  logic                  sample_last;
  logic                  bit_done;
  logic                  frame_done;
  logic                  busy;

  modport master (
    output enable, clear, prescale, frame_bits,
    input  edge_count, bit_count, sample_en, sample_last, bit_done, frame_done, busy
  );

  modport slave (
    input  enable, clear, prescale, frame_bits,
    output edge_count, bit_count, sample_en, sample_last, bit_done, frame_done, busy
  );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// Oversampling bit/frame timing for a UART receiver: tracks edge-within-bit and
// bit-within-frame, and decodes majority-vote sample and completion strobes.
module uart_rx_frame_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sample_en,
  output logic                  sample_last,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [BIT_CNT_W-1:0]  MIN_F = BIT_CNT_W'(MIN_FRAME_BITS);
  localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  ONE_F = BIT_CNT_W'(1);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [BIT_CNT_W-1:0]  f_q, f_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;

  logic                  advance;
  logic                  edge_last;
  logic                  bit_last;
  logic [PRESCALE_W-1:0] mid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      p_q     <= PRESCALE_W'(RST_PRESCALE);
      f_q     <= BIT_CNT_W'(RST_FRAME_BITS);
      edge_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      f_q     <= f_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
    end
  end

  // Strobes are decoded from registered counters so they line up with edge_count.
  assign busy        = (state_q == ST_COUNT);
  assign advance     = busy && enable && !clear;
  assign edge_last   = (edge_q == p_q - ONE_P);
  assign bit_last    = (bit_q == f_q - ONE_F);
  assign mid         = p_q >> 1;
  assign sample_en   = advance && ((edge_q == mid - ONE_P) || (edge_q == mid) ||
                                   (edge_q == mid + ONE_P));
  assign sample_last = advance && (edge_q == mid + ONE_P);
  assign bit_done    = advance && edge_last;
  assign frame_done  = advance && edge_last && bit_last;
  assign edge_count  = edge_q;
  assign bit_count   = bit_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    f_d     = f_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        p_d    = (prescale < MIN_P) ? MIN_P : prescale;
        f_d    = (frame_bits < MIN_F) ? MIN_F : frame_bits;
        edge_d = '0;
        bit_d  = '0;
        // The launching cycle itself is edge 0 of bit 0.
        if (enable && !clear) begin
          state_d = ST_COUNT;
          edge_d  = ONE_P;
        end
      end
      ST_COUNT: begin
        if (clear) begin
          state_d = ST_IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (enable) begin
          if (edge_last) begin
            edge_d = '0;
            if (bit_last) begin
              bit_d   = '0;
              state_d = ST_IDLE;
            end else begin
              bit_d = bit_q + ONE_F;
            end
          end else begin
            edge_d = edge_q + ONE_P;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
